// File: rtl/ram_dma_copy.sv
// Word-copy DMA engine: reads source words on RAM port A and writes them to port B, one word per cycle.
// Define RAM_DMA_FILL_EN to add a pattern-fill mode (fill_i/pattern_i) that writes without reading.
module ram_dma_copy #(
  parameter int LenW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [31:0]     src_addr_i,
  input  logic [31:0]     dst_addr_i,
  input  logic [LenW-1:0] len_i,
  input  logic            abort_i,
`ifdef RAM_DMA_FILL_EN
  input  logic            fill_i,
  input  logic [31:0]     pattern_i,
`endif
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            a_req_o,
  output logic            a_we_o,
  output logic [3:0]      a_be_o,
  output logic [31:0]     a_addr_o,
  output logic [31:0]     a_wdata_o,
  input  logic            a_rvalid_i,
  input  logic [31:0]     a_rdata_i,
  output logic            b_req_o,
  output logic            b_we_o,
  output logic [3:0]      b_be_o,
  output logic [31:0]     b_addr_o,
  output logic [31:0]     b_wdata_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // RUN   | issuing reads (or fill writes), writing returned data
  // DRAIN | reads done, writing the final returned word
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] rd_cnt_q, rd_cnt_d;
  logic [LenW-1:0] wr_cnt_q, wr_cnt_d;
  logic            err_q, err_d;
  logic            fill_mode;
  logic [31:0]     pattern_w;
  logic            last_rd, last_wr;

`ifdef RAM_DMA_FILL_EN
  logic            fill_q, fill_d;
  logic [31:0]     pattern_q, pattern_d;
  assign fill_mode = fill_q;
  assign pattern_w = pattern_q;
`else
  assign fill_mode = 1'b0;
  assign pattern_w = 32'h0;
`endif

  assign last_rd = (rd_cnt_q == len_q - LenW'(1));
  assign last_wr = (wr_cnt_q == len_q - LenW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
`ifdef RAM_DMA_FILL_EN
      fill_q    <= 1'b0;
      pattern_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_q     <= err_d;
`ifdef RAM_DMA_FILL_EN
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_d     = 1'b0;
`ifdef RAM_DMA_FILL_EN
    fill_d    = fill_q;
    pattern_d = pattern_q;
`endif
    a_req_o   = 1'b0;
    a_addr_o  = src_q + (32'(rd_cnt_q) << 2);
    b_req_o   = 1'b0;
    b_addr_o  = dst_q + (32'(wr_cnt_q) << 2);
    b_wdata_o = a_rdata_i;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if ((src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00)) begin
            err_d = 1'b1;
          end else if (len_i == '0) begin
            state_d = S_DONE;
          end else begin
            src_d    = src_addr_i;
            dst_d    = dst_addr_i;
            len_d    = len_i;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
`ifdef RAM_DMA_FILL_EN
            fill_d    = fill_i;
            pattern_d = pattern_i;
`endif
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        // abort suppresses requests in the same cycle it is seen
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (fill_mode) begin
          b_req_o   = 1'b1;
          b_wdata_o = pattern_w;
          wr_cnt_d  = wr_cnt_q + LenW'(1);
          if (last_wr) state_d = S_DONE;
        end else begin
          a_req_o  = 1'b1;
          rd_cnt_d = rd_cnt_q + LenW'(1);
          if (last_rd) state_d = S_DRAIN;
          if (a_rvalid_i) begin
            b_req_o  = 1'b1;
            wr_cnt_d = wr_cnt_q + LenW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (a_rvalid_i) begin
          b_req_o  = 1'b1;
          wr_cnt_d = wr_cnt_q + LenW'(1);
          if (last_wr) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o    = (state_q == S_DONE);
  assign err_o     = err_q;
  assign a_we_o    = 1'b0;
  assign a_be_o    = 4'hF;
  assign a_wdata_o = 32'h0;
  assign b_we_o    = b_req_o;
  assign b_be_o    = 4'hF;

endmodule

// File: tb/tb_ram_dma_copy.sv
// Directed bench for ram_dma_copy with a behavioural dual-port RAM (1-cycle read latency).
// Fill-mode checks are compiled in when RAM_DMA_FILL_EN is defined.
module tb_ram_dma_copy;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [15:0] len_i;
  logic        abort_i;
`ifdef RAM_DMA_FILL_EN
  logic        fill_i;
  logic [31:0] pattern_i;
`endif
  logic        busy_o, done_o, err_o;
  logic        a_req_o, a_we_o;
  logic [3:0]  a_be_o;
  logic [31:0] a_addr_o, a_wdata_o;
  logic        a_rvalid_i;
  logic [31:0] a_rdata_i;
  logic        b_req_o, b_we_o;
  logic [3:0]  b_be_o;
  logic [31:0] b_addr_o, b_wdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [256];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_data = 32'h0;

  logic [31:0] pre [4] = '{32'd11, 32'd22, 32'd33, 32'd44};

  ram_dma_copy #(.LenW(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i), .abort_i(abort_i),
`ifdef RAM_DMA_FILL_EN
    .fill_i(fill_i), .pattern_i(pattern_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .a_req_o(a_req_o), .a_we_o(a_we_o), .a_be_o(a_be_o), .a_addr_o(a_addr_o),
    .a_wdata_o(a_wdata_o), .a_rvalid_i(a_rvalid_i), .a_rdata_i(a_rdata_i),
    .b_req_o(b_req_o), .b_we_o(b_we_o), .b_be_o(b_be_o), .b_addr_o(b_addr_o),
    .b_wdata_o(b_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    a_rvalid_i <= a_req_o && !rst_i;
    a_rdata_i  <= mem[a_addr_o[9:2]];
    if (b_req_o && b_we_o) mem[b_addr_o[9:2]] <= b_wdata_o;
    if (pl_we) mem[pl_idx] <= pl_data;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pl_we   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    step();
    pl_we   = 1'b0;
  endtask

  task automatic start(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
    start_i    = 1'b1;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = len;
    step();
    start_i    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_seen;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    src_addr_i = 32'h0; dst_addr_i = 32'h0; len_i = 16'h0;
`ifdef RAM_DMA_FILL_EN
    fill_i = 1'b0; pattern_i = 32'h0;
`endif
    step(); step(); step();
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset err",  32'(err_o),  32'd0);
    check("reset a_req", 32'(a_req_o), 32'd0);
    check("reset b_req", 32'(b_req_o), 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 4; i++) preload(8'(i), pre[i]);
    preload(8'hFE, 32'hA1);
    preload(8'hFF, 32'hA2);
    preload(8'h81, 32'h0);
    step();

    // copy len=4, with a stray start in cycle 3 that must be ignored
    start(32'h0, 32'h100, 16'd4);
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) begin start_i = 1'b0; #1; end
      check($sformatf("copy c%0d busy", k), 32'(busy_o), 32'(k <= 5));
      check($sformatf("copy c%0d a_req", k), 32'(a_req_o), 32'(k <= 4));
      if (k <= 4) check($sformatf("copy c%0d a_addr", k), a_addr_o, 32'(4 * (k - 1)));
      check($sformatf("copy c%0d b_req", k), 32'(b_req_o), 32'(k >= 2 && k <= 5));
      check($sformatf("copy c%0d b_we", k), 32'(b_we_o), 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        check($sformatf("copy c%0d b_addr", k), b_addr_o, 32'h100 + 32'(4 * (k - 2)));
        check($sformatf("copy c%0d b_wdata", k), b_wdata_o, pre[k - 2]);
      end
      check($sformatf("copy c%0d done", k), 32'(done_o), 32'(k == 6));
      check($sformatf("copy c%0d err", k), 32'(err_o), 32'd0);
      if (k == 3) begin start_i = 1'b1; src_addr_i = 32'h2; len_i = 16'd9; end
      step();
    end
    check("copy c7 done low", 32'(done_o), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("copy mem[%0d]", 64 + i), mem[64 + i], pre[i]);
    check("tied a_we", 32'(a_we_o), 32'd0);
    check("tied a_be", 32'(a_be_o), 32'hF);
    check("tied b_be", 32'(b_be_o), 32'hF);

    // misaligned source, then misaligned destination
    start(32'h2, 32'h100, 16'd4);
    check("missrc c1 err",   32'(err_o),   32'd1);
    check("missrc c1 busy",  32'(busy_o),  32'd0);
    check("missrc c1 a_req", 32'(a_req_o), 32'd0);
    check("missrc c1 b_req", 32'(b_req_o), 32'd0);
    step();
    check("missrc c2 err",   32'(err_o),   32'd0);
    check("missrc c2 busy",  32'(busy_o),  32'd0);
    check("missrc c2 a_req", 32'(a_req_o), 32'd0);
    start(32'h0, 32'h101, 16'd4);
    check("misdst c1 err",  32'(err_o),  32'd1);
    check("misdst c1 busy", 32'(busy_o), 32'd0);
    step();

    // zero length
    start(32'h0, 32'h100, 16'd0);
    check("zero c1 done",  32'(done_o),  32'd1);
    check("zero c1 busy",  32'(busy_o),  32'd0);
    check("zero c1 a_req", 32'(a_req_o), 32'd0);
    check("zero c1 b_req", 32'(b_req_o), 32'd0);
    step();
    check("zero c2 done", 32'(done_o), 32'd0);

    // abort in cycle 3 of a len=8 copy
    start(32'h0, 32'h200, 16'd8);
    wr_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin abort_i = 1'b1; #1; end
      if (k == 4) abort_i = 1'b0;
      if (b_req_o) wr_seen++;
      if (k >= 3) begin
        check($sformatf("abort c%0d a_req", k), 32'(a_req_o), 32'd0);
        check($sformatf("abort c%0d b_req", k), 32'(b_req_o), 32'd0);
      end
      if (k >= 4) check($sformatf("abort c%0d busy", k), 32'(busy_o), 32'd0);
      check($sformatf("abort c%0d done", k), 32'(done_o), 32'd0);
      step();
    end
    check("abort write count", 32'(wr_seen), 32'd1);
    check("abort mem[128]", mem[128], 32'd11);
    check("abort mem[129]", mem[129], 32'd0);

    // source address wrap
    start(32'hFFFFFFF8, 32'h40, 16'd3);
    check("wrap c1 a_addr", a_addr_o, 32'hFFFFFFF8);
    step();
    check("wrap c2 a_addr", a_addr_o, 32'hFFFFFFFC);
    step();
    check("wrap c3 a_addr", a_addr_o, 32'h00000000);
    step();
    check("wrap c4 busy", 32'(busy_o), 32'd1);
    check("wrap c4 a_req", 32'(a_req_o), 32'd0);
    step();
    check("wrap c5 done", 32'(done_o), 32'd1);
    step();
    check("wrap mem[16]", mem[16], 32'hA1);
    check("wrap mem[17]", mem[17], 32'hA2);
    check("wrap mem[18]", mem[18], 32'd11);

`ifdef RAM_DMA_FILL_EN
    fill_i = 1'b1; pattern_i = 32'hDEADBEEF;
    start(32'h0, 32'h20, 16'd2);
    fill_i = 1'b0; pattern_i = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("fill c%0d a_req", k), 32'(a_req_o), 32'd0);
      check($sformatf("fill c%0d b_req", k), 32'(b_req_o), 32'(k <= 2));
      if (k <= 2) begin
        check($sformatf("fill c%0d b_addr", k), b_addr_o, 32'h20 + 32'(4 * (k - 1)));
        check($sformatf("fill c%0d b_wdata", k), b_wdata_o, 32'hDEADBEEF);
      end
      check($sformatf("fill c%0d done", k), 32'(done_o), 32'(k == 3));
      step();
    end
    check("fill mem[8]", mem[8], 32'hDEADBEEF);
    check("fill mem[9]", mem[9], 32'hDEADBEEF);
`endif

    // synchronous reset mid-transfer
    start(32'h0, 32'h300, 16'd8);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst mid busy",  32'(busy_o),  32'd0);
    check("rst mid a_req", 32'(a_req_o), 32'd0);
    check("rst mid b_req", 32'(b_req_o), 32'd0);
    check("rst mid done",  32'(done_o),  32'd0);
    step();
    check("rst mid+1 b_req", 32'(b_req_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
